digit_serial_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor; successor to the combinational 4-bit full_adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, least-significant digit first.
- A start/busy/done handshake controls each operation.
- Provides wide arithmetic at low area for datapaths that can tolerate WIDTH/DIGIT cycles of latency.

---
 rtl/digit_serial_adder.sv | 117 +++++++++++
 tb/tb_digit_serial_adder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits of two WIDTH-bit operands per clock,
// least-significant digit first, under a start/busy/done handshake.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((WIDTH < 2) || (WIDTH % DIGIT != 0)) begin : g_param_check
    $error("digit_serial_adder: WIDTH must be >= 2 and DIGIT must divide WIDTH");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             load, step, last;
  logic             done_r;
  logic [DIGIT:0]   dsum;

  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  endfunction

  // Overflow iff both addends share a sign and the result sign differs.
  function automatic logic signed_ovf(input logic x_msb, input logic y_msb, input logic s_msb);
    return (x_msb == y_msb) && (s_msb != x_msb);
  endfunction

  assign dsum = digit_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry);
  assign busy = (state == RUN);
  assign done = done_r;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_W'(NDIG - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= last;
    end
  end

  // Subtraction is a + ~b + ~cin, so b is inverted and the carry seeded at load time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_r   <= a;
      b_r   <= sub ? ~b : b;
      carry <= cin ^ sub;
      cnt   <= '0;
    end else if (step) begin
      sum[int'(cnt)*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
      carry <= dsum[DIGIT];
      a_r   <= a_r >> DIGIT;
      b_r   <= b_r >> DIGIT;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        cout <= dsum[DIGIT];
        ovf  <= signed_ovf(a_r[DIGIT-1], b_r[DIGIT-1], dsum[DIGIT-1]);
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed table and handshake/reset sequences on DIGIT=4,
// plus a randomized sweep over DIGIT=4,1,8,16 against an arithmetic reference model.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start_v;
  logic        sub, cin;
  logic [15:0] a, b;
  logic [3:0]  busy_w, done_w, cout_w, ovf_w;
  logic [15:0] sum_w [4];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DG = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 16;
    digit_serial_adder #(.WIDTH(16), .DIGIT(DG)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_v[g]),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy_w[g]),
      .done  (done_w[g]),
      .sum   (sum_w[g]),
      .cout  (cout_w[g]),
      .ovf   (ovf_w[g])
    );
  end

  function automatic int ndig_of(input int g);
    case (g)
      0:       return 4;
      1:       return 16;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer a+b+cin or a-b-cin; returns {ovf, cout, sum}.
  function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic s, input logic c);
    int ux, uy, sx, sy, r, sr;
    logic co, ov;
    logic [15:0] rs;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    if (!s) begin
      r  = ux + uy + int'(c);
      sr = sx + sy + int'(c);
      co = (r >= 65536);
    end else begin
      r  = ux - uy - int'(c);
      sr = sx - sy - int'(c);
      co = (ux >= uy + int'(c));
    end
    rs = r[15:0];
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, rs};
  endfunction

  // One operation on the DIGIT=4 instance; reports latency, busy correctness, done pulse count.
  task automatic run0(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                      input logic tc, output int lat, output int busy_ok, output int pulses);
    @(negedge clk);
    a = ta; b = tb_; sub = ts; cin = tc; start_v[0] = 1'b1;
    lat = -1; busy_ok = 1; pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (done_w[0]) begin
        pulses++;
        if (lat < 0) lat = c - 1;
        if (busy_w[0]) busy_ok = 0;
      end else if (lat < 0 && !busy_w[0]) begin
        busy_ok = 0;
      end
    end
  endtask

  // One operation issued to all four instances together.
  task automatic run_all(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                         input logic tc);
    int lat [4];
    int pulses [4];
    logic [17:0] e;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; cin = tc; start_v = 4'hF;
    for (int g = 0; g < 4; g++) begin
      lat[g] = -1;
      pulses[g] = 0;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_v = 4'h0;
      for (int g = 0; g < 4; g++) begin
        if (done_w[g]) begin
          pulses[g]++;
          if (lat[g] < 0) lat[g] = c - 1;
        end
      end
    end
    e = ref_op(ta, tb_, ts, tc);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rnd_lat_i%0d", g), lat[g], ndig_of(g));
      chk($sformatf("rnd_pulses_i%0d", g), pulses[g], 1);
      chk($sformatf("rnd_sum_i%0d a=%h b=%h s=%0d c=%0d", g, ta, tb_, ts, tc), sum_w[g], e[15:0]);
      chk($sformatf("rnd_cout_i%0d", g), cout_w[g], e[16]);
      chk($sformatf("rnd_ovf_i%0d", g), ovf_w[g], e[17]);
    end
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        sub, cin;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  function automatic logic [15:0] pick(input logic [15:0] r);
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return r;
    endcase
  endfunction

  initial begin
    vec_t vt [7];
    int lat, busy_ok, pulses, c;
    logic [15:0] ra, rb;

    vt[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    vt[5] = '{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
    vt[6] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0; start_v = 4'h0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {busy_w[0], done_w[0], cout_w[0], ovf_w[0]}, 4'h0);
    chk("reset_sum", sum_w[0], 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy_w, done_w}, 8'h00);

    for (int i = 0; i < 7; i++) begin
      run0(vt[i].a, vt[i].b, vt[i].sub, vt[i].cin, lat, busy_ok, pulses);
      chk($sformatf("vec%0d_lat", i), lat, 4);
      chk($sformatf("vec%0d_busy", i), busy_ok, 1);
      chk($sformatf("vec%0d_pulse", i), pulses, 1);
      chk($sformatf("vec%0d_sum", i), sum_w[0], vt[i].s);
      chk($sformatf("vec%0d_cout", i), cout_w[0], vt[i].co);
      chk($sformatf("vec%0d_ovf", i), ovf_w[0], vt[i].ov);
    end

    // start while busy is ignored
    @(negedge clk);
    a = 16'h1234; b = 16'h0FCD; sub = 1'b0; cin = 1'b0; start_v[0] = 1'b1;
    c = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      c++;
      start_v[0] = (c == 2);
      if (c == 2) begin
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1;
      end
      if (done_w[0]) break;
    end
    start_v[0] = 1'b0;
    chk("busy_start_lat", c - 1, 4);
    chk("busy_start_sum", sum_w[0], 16'h2201);
    chk("busy_start_ovf", ovf_w[0], 1'b0);

    // back-to-back: start accepted in the done cycle
    repeat (3) @(negedge clk);
    a = 16'h1234; b = 16'h0FCD; sub = 1'b0; cin = 1'b0; start_v[0] = 1'b1;
    c = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      c++;
      if (done_w[0]) break;
    end
    chk("b2b_lat1", c - 1, 4);
    chk("b2b_sum1", sum_w[0], 16'h2201);
    a = 16'h7FFF; b = 16'h0001; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("b2b_busy_done", {busy_w[0], done_w[0]}, 2'b10);
    chk("b2b_sum_held", sum_w[0], 16'h2201);
    c = 1;
    for (int k = 0; k < 10 && !done_w[0]; k++) begin
      @(negedge clk);
      c++;
    end
    chk("b2b_lat2", c - 1, 4);
    chk("b2b_sum2", sum_w[0], 16'h8000);
    chk("b2b_ovf2", ovf_w[0], 1'b1);

    // reset in the second RUN cycle
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; sub = 1'b0; cin = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {busy_w[0], done_w[0], cout_w[0], ovf_w[0]}, 4'h0);
    chk("rst_mid_sum", sum_w[0], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_w[0]) pulses++;
    end
    chk("rst_no_done", pulses, 0);
    run0(16'h1234, 16'h0FCD, 1'b0, 1'b0, lat, busy_ok, pulses);
    chk("rst_fresh_lat", lat, 4);
    chk("rst_fresh_sum", sum_w[0], 16'h2201);

    // randomized sweep across all DIGIT values
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_all(pick(ra), pick(rb), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
